// File: rtl/cell_memory_ctrl.sv
// Cell-memory controller: a DEPTH x DATA_WIDTH RAM with two read ports and one write port,
// plus a bump-pointer heap allocator whose base pointer is loaded from RAM after reset.
module cell_memory_ctrl #(
  parameter int ADDR_WIDTH    = 10,
  parameter int DATA_WIDTH    = 64,
  parameter int DEPTH         = 1024,
  parameter int READ_LATENCY  = 1,
  parameter int FREE_PTR_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  power,
  input  logic [1:0]            func,
  input  logic                  execute,
  input  logic [ADDR_WIDTH-1:0] address1,
  input  logic [ADDR_WIDTH-1:0] address2,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [ADDR_WIDTH-1:0] free_addr,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2,
  output logic                  ready,
  output logic                  done,
  output logic                  oom,
  output logic                  oom_flag,
  output logic                  addr_err,
  output logic [DATA_WIDTH-1:0] mem_data_out1,
  output logic [DATA_WIDTH-1:0] mem_data_out2
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam int SW = DATA_WIDTH + 1;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = 2;

  typedef enum logic [3:0] {
    INIT_RD, INIT_WAIT, INIT_LOAD, INIT_CLR, IDLE, RD_WAIT, RD_DONE, WR, WR_DONE
  } state_e;

  typedef enum logic [1:0] {
    CMD_READ       = 2'd0,
    CMD_WRITE      = 2'd1,
    CMD_ALLOC      = 2'd2,
    CMD_HEAP_RESET = 2'd3
  } cmd_e;

  state_e                state_q, state_d;
  cmd_e                  cmd_q, cmd_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] addr1_q, addr1_d;
  logic [ADDR_WIDTH-1:0] addr2_q, addr2_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  wren_q, wren_d;
  logic [PW-1:0]         free_mem_q, free_mem_d;
  logic [ADDR_WIDTH-1:0] free_addr_q, free_addr_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
  logic [DATA_WIDTH-1:0] rdata2_q, rdata2_d;
  logic                  ready_q, ready_d;
  logic                  done_q, done_d;
  logic                  oom_q, oom_d;
  logic                  oom_flag_q, oom_flag_d;
  logic                  addr_err_q, addr_err_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd1_pipe_q [READ_LATENCY];
  logic [DATA_WIDTH-1:0] rd2_pipe_q [READ_LATENCY];

  logic [SW-1:0] alloc_sum;
  logic          alloc_ok;
  logic          a1_bad;
  logic          a2_bad;

  // The sum is one bit wider than the count so a huge request cannot wrap into range.
  assign alloc_sum = {1'b0, wdata_q} + SW'(free_mem_q);
  assign alloc_ok  = (alloc_sum <= SW'(DEPTH));
  assign a1_bad    = (PW'(address1) >= PW'(DEPTH));
  assign a2_bad    = (PW'(address2) >= PW'(DEPTH));

  // NOTE: RAM storage has no reset; clearing it would turn the array into thousands of flops.
  always_ff @(posedge clk) begin
    if (power && wren_q) mem_q[addr1_q[IW-1:0]] <= wdata_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        rd1_pipe_q[i] <= '0;
        rd2_pipe_q[i] <= '0;
      end
    end else if (power) begin
      rd1_pipe_q[0] <= mem_q[addr1_q[IW-1:0]];
      rd2_pipe_q[0] <= mem_q[addr2_q[IW-1:0]];
      for (int i = 1; i < READ_LATENCY; i++) begin
        rd1_pipe_q[i] <= rd1_pipe_q[i-1];
        rd2_pipe_q[i] <= rd2_pipe_q[i-1];
      end
    end
  end

  assign mem_data_out1 = rd1_pipe_q[READ_LATENCY-1];
  assign mem_data_out2 = rd2_pipe_q[READ_LATENCY-1];

  always_comb begin
    // NOTE: every _d starts from its hold value so no path through the case infers a latch.
    state_d     = state_q;
    cmd_d       = cmd_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    addr1_d     = addr1_q;
    addr2_d     = addr2_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    wren_d      = wren_q;
    free_mem_d  = free_mem_q;
    free_addr_d = free_addr_q;
    rdata1_d    = rdata1_q;
    rdata2_d    = rdata2_q;
    ready_d     = ready_q;
    oom_flag_d  = oom_flag_q;
    done_d      = 1'b0;
    oom_d       = 1'b0;
    addr_err_d  = 1'b0;

    unique case (state_q)
      INIT_RD: begin
        addr1_d = ADDR_WIDTH'(FREE_PTR_ADDR);
        cnt_d   = '0;
        state_d = INIT_WAIT;
      end
      INIT_WAIT: begin
        if (cnt_q == CW'(READ_LATENCY - 1)) state_d = INIT_LOAD;
        else                                cnt_d   = cnt_q + 1'b1;
      end
      INIT_LOAD: begin
        free_mem_d = PW'(mem_data_out1[ADDR_WIDTH-1:0]);
        addr1_d    = '0;
        wdata_d    = '0;
        wren_d     = 1'b1;
        state_d    = INIT_CLR;
      end
      INIT_CLR: begin
        wren_d      = 1'b0;
        free_addr_d = free_mem_q[ADDR_WIDTH-1:0];
        ready_d     = 1'b1;
        state_d     = IDLE;
      end
      IDLE: begin
        if (execute) begin
          ready_d = 1'b0;
          cmd_d   = cmd_e'(func);
          wdata_d = write_data;
          base_d  = address1;
          err_d   = 1'b0;
          state_d = WR_DONE;
          unique case (cmd_e'(func))
            CMD_READ: begin
              if (a1_bad || a2_bad) begin
                err_d = 1'b1;
              end else begin
                addr1_d = address1;
                addr2_d = address2;
                cnt_d   = '0;
                state_d = RD_WAIT;
              end
            end
            CMD_WRITE: begin
              if (a1_bad) begin
                err_d = 1'b1;
              end else begin
                addr1_d = address1;
                state_d = WR;
              end
            end
            default: ;
          endcase
        end
      end
      RD_WAIT: begin
        if (cnt_q == CW'(READ_LATENCY - 1)) state_d = RD_DONE;
        else                                cnt_d   = cnt_q + 1'b1;
      end
      RD_DONE: begin
        rdata1_d = mem_data_out1;
        rdata2_d = mem_data_out2;
        done_d   = 1'b1;
        ready_d  = 1'b1;
        state_d  = IDLE;
      end
      WR: begin
        wren_d  = 1'b1;
        state_d = WR_DONE;
      end
      WR_DONE: begin
        // Shared completion step for writes, allocator commands and rejected addresses.
        wren_d  = 1'b0;
        done_d  = 1'b1;
        ready_d = 1'b1;
        state_d = IDLE;
        if (err_q) begin
          addr_err_d = 1'b1;
        end else if (cmd_q == CMD_ALLOC) begin
          if (alloc_ok) begin
            free_addr_d = free_mem_q[ADDR_WIDTH-1:0];
            free_mem_d  = alloc_sum[PW-1:0];
          end else begin
            oom_d      = 1'b1;
            oom_flag_d = 1'b1;
          end
        end else if (cmd_q == CMD_HEAP_RESET) begin
          free_mem_d = PW'(base_q);
          oom_flag_d = 1'b0;
        end
      end
      default: state_d = INIT_RD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= INIT_RD;
      cmd_q       <= CMD_READ;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      addr1_q     <= '0;
      addr2_q     <= '0;
      base_q      <= '0;
      wdata_q     <= '0;
      wren_q      <= 1'b0;
      free_mem_q  <= '0;
      free_addr_q <= '0;
      rdata1_q    <= '0;
      rdata2_q    <= '0;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
      oom_q       <= 1'b0;
      oom_flag_q  <= 1'b0;
      addr_err_q  <= 1'b0;
    end else if (power) begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      addr1_q     <= addr1_d;
      addr2_q     <= addr2_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      wren_q      <= wren_d;
      free_mem_q  <= free_mem_d;
      free_addr_q <= free_addr_d;
      rdata1_q    <= rdata1_d;
      rdata2_q    <= rdata2_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      oom_q       <= oom_d;
      oom_flag_q  <= oom_flag_d;
      addr_err_q  <= addr_err_d;
    end
  end

  assign free_addr  = free_addr_q;
  assign read_data1 = rdata1_q;
  assign read_data2 = rdata2_q;
  assign ready      = ready_q & ~execute;
  assign done       = done_q;
  assign oom        = oom_q;
  assign oom_flag   = oom_flag_q;
  assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_cell_memory_ctrl.sv
// Directed bench for cell_memory_ctrl: init, read/write, allocator, range errors,
// power gating and reset in the middle of a write.
module tb_cell_memory_ctrl;

  localparam int AW    = 11;
  localparam int DW    = 64;
  localparam int DEPTH = 1024;
  localparam int LAT   = 1;

  localparam logic [1:0] F_RD = 2'd0;
  localparam logic [1:0] F_WR = 2'd1;
  localparam logic [1:0] F_AL = 2'd2;
  localparam logic [1:0] F_HR = 2'd3;

  logic          clk = 1'b0;
  logic          rst;
  logic          power;
  logic [1:0]    func;
  logic          execute;
  logic [AW-1:0] address1;
  logic [AW-1:0] address2;
  logic [DW-1:0] write_data;
  logic [AW-1:0] free_addr;
  logic [DW-1:0] read_data1;
  logic [DW-1:0] read_data2;
  logic          ready;
  logic          done;
  logic          oom;
  logic          oom_flag;
  logic          addr_err;
  logic [DW-1:0] mem_data_out1;
  logic [DW-1:0] mem_data_out2;

  int checks = 0;
  int errors = 0;

  cell_memory_ctrl #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .DEPTH        (DEPTH),
    .READ_LATENCY (LAT),
    .FREE_PTR_ADDR(0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .power        (power),
    .func         (func),
    .execute      (execute),
    .address1     (address1),
    .address2     (address2),
    .write_data   (write_data),
    .free_addr    (free_addr),
    .read_data1   (read_data1),
    .read_data2   (read_data2),
    .ready        (ready),
    .done         (done),
    .oom          (oom),
    .oom_flag     (oom_flag),
    .addr_err     (addr_err),
    .mem_data_out1(mem_data_out1),
    .mem_data_out2(mem_data_out2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    func;
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
    logic [DW-1:0] wd;
    int            gap;     // cycles of power low right after acceptance
    int            lat;     // edges from acceptance to done
    logic          oom;
    logic          err;
    logic          oom_flag;
    logic [AW-1:0] fa;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic          chk_rd;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, DW'({ready, done, oom, oom_flag, addr_err}), '0);
    check({tag, "_free_addr"}, DW'(free_addr), '0);
    check({tag, "_read_data"}, read_data1 | read_data2, '0);
    check({tag, "_mem_out"}, mem_data_out1 | mem_data_out2, '0);
  endtask

  task automatic wait_ready(input string tag);
    bit got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(posedge clk);
      #1;
      if (ready) got = 1'b1;
    end
    check(tag, DW'(got), DW'(1));
  endtask

  task automatic do_cmd(input int idx, input vec_t v);
    int lat = 0;
    bit got = 1'b0;
    string p = $sformatf("v%0d", idx);
    @(negedge clk);
    func       = v.func;
    address1   = v.a1;
    address2   = v.a2;
    write_data = v.wd;
    execute    = 1'b1;
    #1 check({p, "_ready_exec"}, DW'(ready), DW'(0));
    @(posedge clk);
    #1 execute = 1'b0;
    if (v.gap > 0) power = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(posedge clk);
      lat++;
      #1;
      if (lat == v.gap) power = 1'b1;
      if (done) got = 1'b1;
    end
    power = 1'b1;
    check({p, "_latency"}, DW'(lat), DW'(v.lat));
    check({p, "_oom"}, DW'(oom), DW'(v.oom));
    check({p, "_addr_err"}, DW'(addr_err), DW'(v.err));
    check({p, "_oom_flag"}, DW'(oom_flag), DW'(v.oom_flag));
    check({p, "_free_addr"}, DW'(free_addr), DW'(v.fa));
    check({p, "_ready"}, DW'(ready), DW'(1));
    if (v.chk_rd) begin
      check({p, "_rd1"}, read_data1, v.rd1);
      check({p, "_rd2"}, read_data2, v.rd2);
    end
    @(posedge clk);
    #1 check({p, "_pulses_clear"}, DW'({done, oom, addr_err}), DW'(0));
  endtask

  initial begin
    //            func  a1        a2        wd                      gap lat oom  err  flag fa        rd1        rd2       chk
    vecs[0]  = '{F_WR, 11'h005, 11'h000, 64'hDEAD,               0,  2, 1'b0,1'b0,1'b0, 11'h100, 64'h0,     64'h0,    1'b1};
    vecs[1]  = '{F_RD, 11'h005, 11'h000, 64'h0,                  0,  2, 1'b0,1'b0,1'b0, 11'h100, 64'hDEAD,  64'h0,    1'b1};
    vecs[2]  = '{F_HR, 11'h3F0, 11'h000, 64'h0,                  0,  1, 1'b0,1'b0,1'b0, 11'h100, 64'hDEAD,  64'h0,    1'b1};
    vecs[3]  = '{F_AL, 11'h000, 11'h000, 64'd16,                 0,  1, 1'b0,1'b0,1'b0, 11'h3F0, 64'hDEAD,  64'h0,    1'b1};
    vecs[4]  = '{F_AL, 11'h000, 11'h000, 64'd1,                  0,  1, 1'b1,1'b0,1'b1, 11'h3F0, 64'hDEAD,  64'h0,    1'b1};
    vecs[5]  = '{F_AL, 11'h000, 11'h000, 64'd0,                  0,  1, 1'b0,1'b0,1'b1, 11'h400, 64'hDEAD,  64'h0,    1'b1};
    vecs[6]  = '{F_HR, 11'h200, 11'h000, 64'h0,                  0,  1, 1'b0,1'b0,1'b0, 11'h400, 64'hDEAD,  64'h0,    1'b1};
    vecs[7]  = '{F_AL, 11'h000, 11'h000, 64'd4,                  0,  1, 1'b0,1'b0,1'b0, 11'h200, 64'hDEAD,  64'h0,    1'b1};
    vecs[8]  = '{F_AL, 11'h000, 11'h000, 64'hFFFF_FFFF_FFFF_FFFF,0,  1, 1'b1,1'b0,1'b1, 11'h200, 64'hDEAD,  64'h0,    1'b1};
    vecs[9]  = '{F_WR, 11'h400, 11'h000, 64'hBAD,                0,  1, 1'b0,1'b1,1'b1, 11'h200, 64'hDEAD,  64'h0,    1'b1};
    vecs[10] = '{F_RD, 11'h3FF, 11'h400, 64'h0,                  0,  1, 1'b0,1'b1,1'b1, 11'h200, 64'hDEAD,  64'h0,    1'b1};
    vecs[11] = '{F_WR, 11'h3FF, 11'h000, 64'h1234,               0,  2, 1'b0,1'b0,1'b1, 11'h200, 64'hDEAD,  64'h0,    1'b1};
    vecs[12] = '{F_RD, 11'h3FF, 11'h005, 64'h0,                  0,  2, 1'b0,1'b0,1'b1, 11'h200, 64'h1234,  64'hDEAD, 1'b1};
    vecs[13] = '{F_RD, 11'h005, 11'h3FF, 64'h0,                  3,  5, 1'b0,1'b0,1'b1, 11'h200, 64'hDEAD,  64'h1234, 1'b1};
    vecs[14] = '{F_AL, 11'h000, 11'h000, 64'h1FC,                0,  1, 1'b0,1'b0,1'b1, 11'h204, 64'hDEAD,  64'h1234, 1'b1};
    vecs[15] = '{F_RD, 11'h000, 11'h3FF, 64'h0,                  0,  2, 1'b0,1'b0,1'b1, 11'h204, 64'h0,     64'h1234, 1'b1};
    vecs[16] = '{F_WR, 11'h007, 11'h000, 64'h77,                 0,  2, 1'b0,1'b0,1'b1, 11'h204, 64'h0,     64'h1234, 1'b1};

    rst        = 1'b0;
    power      = 1'b1;
    execute    = 1'b0;
    func       = F_RD;
    address1   = '0;
    address2   = '0;
    write_data = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    wait_ready("init1_ready");

    // Seed the heap pointer word, then re-run init so it is picked up.
    @(negedge clk);
    func       = F_WR;
    address1   = '0;
    write_data = 64'h100;
    execute    = 1'b1;
    @(posedge clk);
    #1 execute = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 check_reset_outputs("rst2");
    @(negedge clk);
    rst = 1'b1;
    wait_ready("init2_ready");
    check("init2_free_addr", DW'(free_addr), DW'(11'h100));

    for (int i = 0; i < 17; i++) do_cmd(i, vecs[i]);

    // Reset asynchronously while the write strobe is high.
    @(negedge clk);
    func       = F_WR;
    address1   = 11'h007;
    write_data = 64'hCAFE;
    execute    = 1'b1;
    @(posedge clk);
    #1 execute = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b1;
    wait_ready("midrst_ready");
    check("midrst_free_addr", DW'(free_addr), DW'(0));
    do_cmd(17, '{F_RD, 11'h007, 11'h000, 64'h0, 0, 2, 1'b0, 1'b0, 1'b0, 11'h000, 64'h0, 64'h0, 1'b0});
    check("midrst_word_whole", DW'(read_data1 == 64'h77 || read_data1 == 64'hCAFE), DW'(1));
    check("midrst_nil_cell", read_data2, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cell_memory_ctrl.md
CELL_MEMORY_CTRL -- requirements
Module: cell_memory_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 10, meaning the word-address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 64, meaning the cell word width.
REQ-003 The block SHALL have parameter DEPTH, default 1024, meaning the number of words (DEPTH <= 2**ADDR_WIDTH).
REQ-004 The block SHALL have parameter READ_LATENCY, default 1, meaning the RAM read latency in cycles (range 1..4).
REQ-005 The block SHALL have parameter FREE_PTR_ADDR, default 0, meaning the word holding the initial heap pointer.
REQ-006 The block SHALL have ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- power  in  1  clock enable; all state holds while low.
- func  in  2  command: 0 READ, 1 WRITE, 2 ALLOC, 3 HEAP_RESET.
- execute  in  1  command request.
- address1, address2  in  ADDR_WIDTH  operand addresses.
- write_data  in  DATA_WIDTH  write value, or ALLOC count.
- free_addr  out  ADDR_WIDTH  base of the last successful allocation.
- read_data1, read_data2  out  DATA_WIDTH  READ results.
- ready  out  1  equals ready_reg AND NOT execute.
- done  out  1  one-cycle completion pulse.
- oom  out  1  one-cycle allocation-failure pulse.
- oom_flag  out  1  sticky out-of-memory flag.
- addr_err  out  1  one-cycle out-of-range-address pulse.
- mem_data_out1, mem_data_out2  out  DATA_WIDTH  raw RAM ports, for debug.

Function
REQ-007 The block SHALL instantiate one synchronous two-read-port, one-write-port RAM of DEPTH x DATA_WIDTH; a write occurs on port 1 only.
REQ-008 The RAM write enable SHALL be the registered wren ANDed with power.
REQ-009 The states SHALL be INIT_RD, INIT_WAIT, INIT_LOAD, INIT_CLR, IDLE, RD_WAIT, RD_DONE, WR, WR_DONE.
REQ-010 INIT_RD SHALL present FREE_PTR_ADDR on port 1.
REQ-011 INIT_WAIT SHALL wait READ_LATENCY cycles.
REQ-012 INIT_LOAD SHALL load free_mem from the low ADDR_WIDTH bits of port-1 data.
REQ-013 INIT_CLR SHALL write 0 to address 0 (the nil cell) with wren high for exactly one cycle.
REQ-014 After INIT_CLR, free_addr SHALL equal free_mem, ready_reg SHALL be 1, and the state SHALL be IDLE.
REQ-015 A command SHALL be accepted only in IDLE with execute=1; at acceptance (edge T) ready_reg SHALL clear.
REQ-016 The requester SHALL deassert execute before done; any execute high in IDLE is a new command.
REQ-017 READ SHALL register read_data1 from mem[address1] and read_data2 from mem[address2], with done at T+1+READ_LATENCY.
REQ-018 WRITE SHALL hold wren high exactly during cycle T+1 and assert done at T+2.
REQ-019 For ALLOC with count = write_data, sum = free_mem + count SHALL be computed at DATA_WIDTH+1 bits without wrap.
REQ-020 If sum <= DEPTH, ALLOC SHALL set free_addr to free_mem and free_mem to sum, with done at T+1.
REQ-021 A count of 0 SHALL succeed and leave free_mem unchanged.
REQ-022 If sum > DEPTH, ALLOC SHALL pulse oom with done at T+1, set oom_flag, and leave free_addr and free_mem unchanged; it SHALL never hang or stop.
REQ-023 HEAP_RESET SHALL set free_mem to address1, clear oom_flag, and assert done at T+1; free_addr SHALL be unchanged.
REQ-024 For READ or WRITE with any address >= DEPTH, the block SHALL pulse addr_err with done at T+1, suppress the write, and leave read_data unchanged.
REQ-025 Simultaneous events: execute during a busy state SHALL be ignored.
REQ-026 While power is low, every register, including the init sequence, SHALL freeze and resume on return.
REQ-027 ready_reg SHALL be set in the same cycle as done.

Reset
REQ-028 On rst low, the block SHALL set state to INIT_RD and clear free_mem, free_addr, read_data1/2, wren, ready_reg, done, oom, oom_flag and addr_err to 0, immediately and regardless of clk or power.
REQ-029 Reset mid-command SHALL abort the command with no partial write beyond the current cycle and SHALL re-run init.

Verification
REQ-030 Init: preload mem[0]=0x100, release rst -> ready=1 after init, free_addr=0x100, mem[0]=0.
REQ-031 Write/read: WRITE addr 5 data 0xDEAD, then READ addr1=5 addr2=0 -> read_data1=0xDEAD, read_data2=0, done at T+2 for READ_LATENCY=1.
REQ-032 Allocation: free_mem=0x3F0, ALLOC 16 -> free_addr=0x3F0 and free_mem=0x400; then ALLOC 1 -> oom pulse, oom_flag=1, free_addr still 0x3F0.
REQ-033 Heap reset: HEAP_RESET address1=0x200 -> oom_flag=0; next ALLOC 4 -> free_addr=0x200.
REQ-034 Range and power: WRITE to address DEPTH -> addr_err=1 and no RAM change; power low for 3 cycles mid-READ -> same result, delayed by 3 cycles.
REQ-035 Mid-command reset: rst low during WR -> all outputs 0, init re-executes, and the target word is either fully written or untouched.
